// File: rtl/truth_table_sweep_pkg.sv
// Shared types and sizing for the truth-table sweeper: FSM state encoding,
// vector count and counter widths.
package truth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int CNT_W       = 8;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

endpackage

// File: rtl/truth_table_sweep_if.sv
// Stimulus/response bundle between the sweeper and the 3-input gate network
// under test, plus the sweep control and result signals.
interface truth_table_sweep_if;
    import truth_pkg::*;

    logic                   start;
    logic                   x;
    logic                   y;
    logic                   z;
    logic                   f;
    logic [NUM_VECTORS-1:0] exp_tbl;
    logic                   busy;
    logic                   done;
    logic [NUM_VECTORS-1:0] tbl;
    logic                   match;

    modport master (
        input  start, f, exp_tbl,
        output x, y, z, busy, done, tbl, match
    );

    modport slave (
        output start, f, exp_tbl,
        input  x, y, z, busy, done, tbl, match
    );

endinterface

// File: rtl/truth_table_sweep_settle_counter.sv
// Per-vector hold-time counter: counts the cycles a vector has been driven and
// flags the SETTLE-th cycle, at whose closing edge the response is sampled.
module settle_counter
    import truth_pkg::*;
#(
    parameter int SETTLE = 3  // legal range 1..255
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // cnt_q is zero-based, so the SETTLE-th cycle of a vector is cnt_q == SETTLE-1
    assign tc_o = en_i && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_sweep.sv
// Drives all eight {x,y,z} vectors into an external 3-input gate network,
// captures its response into a truth table and compares it with the expected one.
module truth_table_sweep
    import truth_pkg::*;
#(
    parameter int SETTLE = 3  // legal range 1..255
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_sweep_if.master   bus
);

    state_e                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       vec_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   match_q;
    logic [NUM_VECTORS-1:0] tbl_q;
    logic [NUM_VECTORS-1:0] tbl_d;

    logic                   cnt_load;
    logic                   cnt_en;
    logic                   cnt_tc;

    assign cnt_load = (state_q == ST_IDLE) && bus.start;
    assign cnt_en   = (state_q == ST_DRIVE);

    settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        tbl_d        = tbl_q;
        tbl_d[idx_q] = bus.f;
    end

    // The vector is its own register rather than derived from idx_q, so the
    // gate network inputs never glitch while idx_q or the state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            tbl_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    vec_q  <= '0;
                    if (bus.start) begin
                        state_q <= ST_DRIVE;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        tbl_q   <= '0;
                        match_q <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_tc) begin
                        tbl_q <= tbl_d;
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                            idx_q   <= '0;
                            vec_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            // exp_tbl is only looked at on this edge
                            match_q <= (tbl_d == bus.exp_tbl);
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            vec_q <= idx_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    vec_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x     = vec_q[2];
    assign bus.y     = vec_q[1];
    assign bus.z     = vec_q[0];
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.tbl   = tbl_q;
    assign bus.match = match_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep: one instance with SETTLE=3 driving F=~x&y and one
// with SETTLE=1 against f tied high; a done-triggered monitor scores results.
module tb_truth_table_sweep;
    import truth_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_sweep_if if3();
    truth_table_sweep_if if1();

    assign if3.f = ~if3.x & if3.y;
    assign if1.f = 1'b1;

    truth_table_sweep #(.SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.master));
    truth_table_sweep #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));

    typedef struct {
        logic [7:0] tbl;
        logic       match;
        int         start_cyc;
    } exp_t;

    exp_t q3[$];
    exp_t q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitors: one expected entry is consumed per done pulse
    always @(negedge clk) begin
        exp_t e;
        if (!rst && if3.done) begin
            if (q3.size() == 0) begin
                check("done3_unexpected", 1, 0);
            end else begin
                e = q3.pop_front();
                check("tbl3", if3.tbl, e.tbl);
                check("match3", if3.match, e.match);
                check("latency3", cyc - e.start_cyc, 8 * 3 + 1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && if1.done) begin
            if (q1.size() == 0) begin
                check("done1_unexpected", 1, 0);
            end else begin
                e = q1.pop_front();
                check("tbl1", if1.tbl, e.tbl);
                check("match1", if1.match, e.match);
                check("latency1", cyc - e.start_cyc, 8 * 1 + 1);
            end
        end
    end

    // Stability checkers: each vector held exactly SETTLE cycles, idle vector 000
    int         held3 = 0, held1 = 0;
    logic [2:0] pv3 = '0, pv1 = '0;
    logic       pb3 = 1'b0, pb1 = 1'b0;

    always @(negedge clk) begin
        logic [2:0] v;
        v = {if3.x, if3.y, if3.z};
        if (rst) begin
            held3 = 0;
            pb3   = 1'b0;
        end else begin
            check("busy_and_done3", if3.busy & if3.done, 0);
            if (if3.busy) begin
                if (pb3 && v == pv3) held3++;
                else begin
                    if (pb3) check("hold3", held3, 3);
                    held3 = 1;
                end
            end else begin
                check("idle_vec3", v, 0);
                if (pb3 && if3.done) check("hold3_last", held3, 3);
            end
            pv3 = v;
            pb3 = if3.busy;
        end
    end

    always @(negedge clk) begin
        logic [2:0] v;
        v = {if1.x, if1.y, if1.z};
        if (rst) begin
            held1 = 0;
            pb1   = 1'b0;
        end else begin
            check("busy_and_done1", if1.busy & if1.done, 0);
            if (if1.busy) begin
                if (pb1 && v == pv1) held1++;
                else begin
                    if (pb1) check("hold1", held1, 1);
                    held1 = 1;
                end
            end else begin
                check("idle_vec1", v, 0);
                if (pb1 && if1.done) check("hold1_last", held1, 1);
            end
            pv1 = v;
            pb1 = if1.busy;
        end
    end

    function automatic logic done_of(input int sel);
        return (sel == 3) ? if3.done : if1.done;
    endfunction

    task automatic wait_done(input int sel, input int budget);
        int n = 0;
        while (!done_of(sel) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done_of(sel)) check("done_timeout", 0, 1);
    endtask

    task automatic push3(input logic [7:0] t, input logic m, input int s);
        exp_t e;
        e.tbl = t; e.match = m; e.start_cyc = s;
        q3.push_back(e);
    endtask

    // Raise start for one cycle on the SETTLE=3 instance; returns its start cycle
    task automatic pulse3(output int s);
        s = cyc;
        if3.start = 1'b1;
        @(negedge clk);
        if3.start = 1'b0;
    endtask

    initial begin
        int s;
        exp_t e;
        rst = 1'b1;
        if3.start = 1'b0; if3.exp_tbl = 8'h0C;
        if1.start = 1'b0; if1.exp_tbl = 8'hFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_busy", if3.busy, 0);
        check("rst_done", if3.done, 0);
        check("rst_tbl", if3.tbl, 8'h00);
        check("rst_match", if3.match, 0);
        check("rst_xyz", {if3.x, if3.y, if3.z}, 3'b000);
        check("rst_tbl1", if1.tbl, 8'h00);

        // Reset mid-sweep: vectors 0..2 captured, then rst clears everything
        pulse3(s);
        while (cyc < s + 10) @(negedge clk);
        check("pre_rst_tbl", if3.tbl, 8'h04);
        check("pre_rst_xyz", {if3.x, if3.y, if3.z}, 3'b011);
        check("pre_rst_busy", if3.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", if3.busy, 0);
        check("midrst_tbl", if3.tbl, 8'h00);
        check("midrst_xyz", {if3.x, if3.y, if3.z}, 3'b000);
        check("midrst_done", if3.done, 0);
        repeat (30) @(negedge clk);
        check("midrst_stays_idle", if3.busy, 0);

        // Golden sweep with xyz stepping every 3 cycles
        if3.exp_tbl = 8'h0C;
        push3(8'h0C, 1'b1, cyc);
        pulse3(s);
        for (int k = 0; k < 8; k++) begin
            check("step_xyz", {if3.x, if3.y, if3.z}, k);
            repeat (3) @(negedge clk);
        end
        check("golden_done_cycle", if3.done, 1);
        @(negedge clk);
        if3.exp_tbl = 8'hAA;
        repeat (2) @(negedge clk);
        check("match_holds_in_idle", if3.match, 1);
        check("tbl_holds_in_idle", if3.tbl, 8'h0C);

        // Mismatching expected table
        if3.exp_tbl = 8'h0D;
        push3(8'h0C, 1'b0, cyc);
        pulse3(s);
        wait_done(3, 40);
        repeat (3) @(negedge clk);
        check("mismatch_match_idle", if3.match, 0);

        // SETTLE=1 with f tied high
        e.tbl = 8'hFF; e.match = 1'b1; e.start_cyc = cyc;
        q1.push_back(e);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        wait_done(1, 20);
        repeat (3) @(negedge clk);

        // Extra start pulses while busy and in DONE are ignored
        if3.exp_tbl = 8'h0C;
        push3(8'h0C, 1'b1, cyc);
        pulse3(s);
        repeat (4) @(negedge clk);
        if3.start = 1'b1;
        @(negedge clk);
        if3.start = 1'b0;
        wait_done(3, 40);
        if3.start = 1'b1;
        @(negedge clk);
        if3.start = 1'b0;
        check("ignored_start_idle", if3.busy, 0);
        repeat (30) @(negedge clk);
        check("ignored_start_no_sweep", if3.busy, 0);

        // start held high: back-to-back sweeps with one IDLE cycle in between
        s = cyc;
        push3(8'h0C, 1'b1, s);
        push3(8'h0C, 1'b1, s + 26);
        if3.start = 1'b1;
        wait_done(3, 40);
        @(negedge clk);
        check("b2b_idle_busy", if3.busy, 0);
        check("b2b_idle_done", if3.done, 0);
        @(negedge clk);
        check("b2b_restart_busy", if3.busy, 1);
        if3.start = 1'b0;
        wait_done(3, 40);
        repeat (30) @(negedge clk);

        check("q3_drained", q3.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweep.md
TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 Parameter SETTLE, default 3: clock cycles each input vector is held before the response is sampled; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request for one full sweep; sampled only in IDLE.
REQ-005 x  output  1  vector bit 2 (MSB) driven to the downstream 3-input gate network.
REQ-006 y  output  1  vector bit 1.
REQ-007 z  output  1  vector bit 0 (LSB).
REQ-008 f  input  1  response of the gate network to {x,y,z}.
REQ-009 exp_tbl  input  8  expected truth table; bit i is the expected f for {x,y,z}=i.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  single-cycle pulse when a sweep completes.
REQ-012 tbl  output  8  captured truth table; bit i is f sampled for vector i.
REQ-013 match  output  1  high when tbl equals exp_tbl at completion.

Function
REQ-014 FSM states: IDLE, DRIVE, DONE; encoding is free.
REQ-015 IDLE: {x,y,z}=000, busy=0, done=0; tbl and match hold their last values.
REQ-016 start=1 at an IDLE edge: go to DRIVE, vector index=0, settle count=0, busy=1, tbl cleared to 0, match cleared to 0.
REQ-017 DRIVE: {x,y,z} equals the vector index, registered, and glitch-free for the whole hold window.
REQ-018 Each vector is held for exactly SETTLE cycles; f is sampled into tbl[index] at the edge that ends the SETTLE-th cycle.
REQ-019 The same edge increments the index, so the next vector appears the cycle after sampling; there are no idle cycles between vectors.
REQ-020 Index 7 sampled: go to DONE; {x,y,z} returns to 000 and busy=0.
REQ-021 DONE lasts one cycle: done=1, tbl final, match=(tbl==exp_tbl); next state is IDLE unconditionally.
REQ-022 done asserts exactly 8*SETTLE+1 cycles after the start edge.
REQ-023 exp_tbl is sampled only when match is computed; changes at any other time have no effect.
REQ-024 start while busy or in DONE is ignored; it is not queued.
REQ-025 start held high continuously: a new sweep starts on the first IDLE edge after DONE.
REQ-026 Index counter is 3 bits; wrap past 7 is never observable, because DONE is entered instead.
REQ-027 Settle counter width is 8 bits; SETTLE=1 samples every cycle.

Reset
REQ-028 rst=1 at an edge, in any state including mid-sweep, forces IDLE with x=y=z=0, busy=0, done=0, tbl=0, match=0, and clears the index and settle counters.
REQ-029 rst takes priority over start in the same cycle.

Structure
REQ-030 Shared package truth_pkg holds the state enum, NUM_VECTORS=8, IDX_W=3, and CNT_W=8.
REQ-031 One sub-module, settle_counter: load/enable inputs and a terminal-count output equal to SETTLE; the FSM, index, and capture logic stay in the top level.
REQ-032 The downstream gate network is instantiated only in the testbench, never inside this block.

Verification
REQ-033 Reset mid-sweep: SETTLE=3, start, rst asserted at cycle 10 -> next cycle busy=0, tbl=00, xyz=000, done never pulses.
REQ-034 Golden sweep: SETTLE=3, f driven by the gate network F=~x&y, exp_tbl=0C, start pulse -> xyz steps 000..111 every 3 cycles, done at start+25, tbl=0C, match=1.
REQ-035 Mismatch: same setup with exp_tbl=0D -> tbl=0C, match=0, done still pulses once.
REQ-036 SETTLE=1 with f tied to 1 -> done at start+9, tbl=FF.
REQ-037 Ignored start: pulse start again during the sweep -> exactly one done; then with start held high -> back-to-back sweeps with exactly one IDLE cycle between done and the new busy.
REQ-038 Stability: a checker asserts {x,y,z} is constant within every SETTLE window and that busy and done are never both high.
